// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg : opcode/funct, state, extender, ALU and PC-source encodings
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;
  localparam logic [1:0] EOP_SHL2 = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  typedef struct packed {
    logic       is_r;
    logic       is_subu;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_j;
    logic       is_imm;
    logic       is_ori;
    logic [1:0] eop_next;
    logic       illegal_op;
  } dec_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode : combinational instruction classifier for the control FSM
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = opcode_of(instr);
  assign funct         = funct_of(instr);
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec          = '0;
    dec.eop_next = EOP_SIGN;
    case (opcode)
      OP_RTYPE: begin
        // Only addu/subu are implemented; any other funct is illegal.
        if (funct == FN_ADDU) begin
          dec.is_r = 1'b1;
        end else if (funct == FN_SUBU) begin
          dec.is_r    = 1'b1;
          dec.is_subu = 1'b1;
        end else begin
          dec.illegal_op = 1'b1;
        end
      end
      OP_J:     dec.is_j = 1'b1;
      OP_BEQ: begin
        dec.is_beq   = 1'b1;
        dec.eop_next = EOP_SHL2;
      end
      OP_ADDIU: dec.is_imm = 1'b1;
      OP_ORI: begin
        dec.is_imm   = 1'b1;
        dec.is_ori   = 1'b1;
        dec.eop_next = EOP_ZERO;
      end
      OP_LUI: begin
        dec.is_imm   = 1'b1;
        dec.eop_next = EOP_LUI;
      end
      OP_LW:    dec.is_lw = 1'b1;
      OP_SW:    dec.is_sw = 1'b1;
      default:  dec.illegal_op = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl : multi-cycle MIPS control FSM with req/ready memory and timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic [1:0]  eop,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]       state_q,   state_d;
  logic [1:0]       eop_q,     eop_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_hit;
  logic             mem_wait;
  dec_t             dec;

  mc_ctrl_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  // The current unanswered cycle is the TIMEOUT-th one when cnt_q == TIMEOUT-1.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign mem_wait    = mem_req && !mem_ready;

  always_comb begin
    state_d = state_q;
    eop_d   = eop_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DECODE: begin
        eop_d = dec.eop_next;
        if (dec.illegal_op) state_d = S_ERR;
        else if (dec.is_j)  state_d = S_FETCH;
        else                state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec.is_beq)                 state_d = S_FETCH;
        else if (dec.is_lw || dec.is_sw) state_d = S_MEM;
        else                            state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)        state_d = dec.is_sw ? S_FETCH : S_WB;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Any state change clears the counter, covering entry to FETCH and MEM.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + CNT_W'(1);
  end

  assign illegal_d = illegal_q || (state_d == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      eop_q     <= EOP_SIGN;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      eop_q     <= eop_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PCSRC_SEQ;
    eop        = eop_q;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
      end
      S_DECODE: begin
        // Extender mode is visible already while decoding, then held.
        eop = dec.eop_next;
        if (!dec.illegal_op && dec.is_j) begin
          pc_wr  = 1'b1;
          pc_src = PCSRC_JMP;
        end
      end
      S_EXEC: begin
        if (dec.is_r) begin
          alu_op = dec.is_subu ? ALU_SUB : ALU_ADD;
        end else if (dec.is_ori) begin
          alu_op    = ALU_OR;
          alu_src_b = 1'b1;
        end else if (dec.is_beq) begin
          alu_op = ALU_SUB;
          pc_wr  = zero;
          pc_src = PCSRC_BR;
        end else begin
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec.is_sw;
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = dec.is_r ? REGDST_RD : REGDST_RT;
        mem_to_reg = dec.is_lw;
      end
      default: ;
    endcase
    // While reset is held the flops already show FETCH; drop the request too.
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      reg_wr  = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

`default_nettype wire
